// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer.
//   - ALU opcode encoding (matches the ALU's opcode input)
//   - sequencer FSM state encoding
//   - width helper for counters that must hold 0..DEPTH
package alu_op_sequencer_pkg;

  localparam int unsigned OpcodeW = 3;

  typedef enum logic [OpcodeW-1:0] {
    OpAdd    = 3'd0,
    OpSub    = 3'd1,
    OpMult   = 3'd2,
    OpShiftl = 3'd3,
    OpAnd    = 3'd4,
    OpOr     = 3'd5,
    OpXor    = 3'd6,
    OpNot    = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StDrain = 3'd2,
    StFlush = 3'd3,
    StDone  = 3'd4
  } seq_state_e;

  // Bits needed to count from 0 up to and including depth.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// Instruction FIFO for the ALU op sequencer.
// First-word-fall-through: the head entry is visible on rdata whenever empty=0.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (clears pointers and count)
//   push, wdata  write request and data; accepted when not full, or when full and popping
//   pop          remove the head entry; ignored when empty
//   rdata        head entry (stale when empty)
//   full, empty  occupancy flags
module seq_fifo
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = count_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rptr_q];

  assign do_pop  = pop & ~empty;
  // A pop frees the slot this cycle, so a full FIFO can still take a push.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: buffers instruction chains from a valid/ready source and issues each
// complete chain to the ALU back-to-back, one op per clock. The ALU cannot stall, so a
// chain only starts once its final entry is buffered. The final accumulator (or the value
// that raised carry/borrow/overflow) is returned on a valid/ready result port.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            instruction handshake (in_ready = FIFO not full)
//   in_opcode, in_a, in_b        op and operands; in_a only matters for a chain's first op
//   in_last                      final op of the chain (forced after DEPTH entries)
//   alu_rst                      ALU reset; high whenever no op is being issued
//   alu_opcode, alu_a, alu_b     ALU inputs, driven from the FIFO head
//   alu_out, alu_status          registered ALU result and error flag of the previous op
//   res_valid/res_ready          result handshake
//   res_data, res_error, res_ops result value, error flag, ops executed (incl. erroring op)
//   busy                         FSM not idle
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 16,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OpcodeW-1:0] in_opcode,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic               in_last,
  output logic               alu_rst,
  output logic [OpcodeW-1:0] alu_opcode,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  input  logic [W-1:0]       alu_out,
  input  logic               alu_status,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_data,
  output logic               res_error,
  output logic [CW-1:0]      res_ops,
  output logic               busy
);

  typedef struct packed {
    logic               last;
    logic [OpcodeW-1:0] opcode;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
  } entry_t;

  localparam int unsigned EntryW = $bits(entry_t);

  // ---------------------------------------------------------------------------------------
  // Instruction FIFO
  // ---------------------------------------------------------------------------------------
  entry_t push_entry;
  entry_t head;
  logic   fifo_full, fifo_empty;
  logic   push, pop;
  logic   eff_last;
  logic   head_last;

  seq_state_e state_q;

  logic [CW-1:0] push_len_q, push_len_d;
  logic [CW-1:0] last_cnt_q, last_cnt_d;

  // Chains longer than the FIFO could never be fully buffered, so the DEPTH-th entry of a
  // chain is always treated as its last.
  assign eff_last = in_last | (push_len_q == CW'(DEPTH - 1));

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  always_comb begin
    push_entry        = '0;
    push_entry.last   = eff_last;
    push_entry.opcode = in_opcode;
    push_entry.a      = in_a;
    push_entry.b      = in_b;
  end

  // RUN and FLUSH both consume one entry per cycle; RUN discards the entry at the head when
  // an error is reported, just as FLUSH does.
  assign pop       = ((state_q == StRun) | (state_q == StFlush)) & ~fifo_empty;
  assign head_last = ~fifo_empty & head.last;

  seq_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------------------
  // Chain bookkeeping: entries in the chain being pushed, and complete chains buffered
  // ---------------------------------------------------------------------------------------
  always_comb begin
    push_len_d = push_len_q;
    if (push) begin
      push_len_d = eff_last ? '0 : push_len_q + CW'(1);
    end
  end

  always_comb begin
    last_cnt_d = last_cnt_q;
    unique case ({push & eff_last, pop & head_last})
      2'b10:   last_cnt_d = last_cnt_q + CW'(1);
      2'b01:   last_cnt_d = last_cnt_q - CW'(1);
      default: last_cnt_d = last_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_len_q <= '0;
      last_cnt_q <= '0;
    end else begin
      push_len_q <= push_len_d;
      last_cnt_q <= last_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Issue FSM with registered result outputs
  // ---------------------------------------------------------------------------------------
  logic          first_q;
  logic [CW-1:0] ops_q;
  logic          res_valid_q;
  logic [W-1:0]  res_data_q;
  logic          res_error_q;
  logic [CW-1:0] res_ops_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      first_q     <= 1'b0;
      ops_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
      res_ops_q   <= '0;
    end else begin
      if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
      // res_valid is raised on the transition into DONE so that it is visible while the
      // FSM sits in DONE, two cycles after the final issue.
      unique case (state_q)
        StIdle: begin
          if ((last_cnt_q != '0) && !res_valid_q) begin
            state_q <= StRun;
            first_q <= 1'b1;
            ops_q   <= '0;
          end
        end
        StRun: begin
          first_q <= 1'b0;
          if (alu_status) begin
            // The previous op failed; the head entry is dropped without being executed.
            res_data_q  <= alu_out;
            res_error_q <= 1'b1;
            res_ops_q   <= ops_q;
            if (head_last) begin
              state_q     <= StDone;
              res_valid_q <= 1'b1;
            end else begin
              state_q <= StFlush;
            end
          end else begin
            ops_q <= ops_q + CW'(1);
            if (head_last) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // Final op's result and status arrive one cycle after its issue.
          res_data_q  <= alu_out;
          res_error_q <= alu_status;
          res_ops_q   <= ops_q;
          res_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StFlush: begin
          if (head_last) begin
            state_q     <= StDone;
            res_valid_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------
  // ALU drive and outputs
  // ---------------------------------------------------------------------------------------
  // Holding the ALU in reset on an error stops the failing chain from executing further.
  assign alu_rst    = (state_q != StRun) | ((state_q == StRun) & alu_status);
  assign alu_opcode = head.opcode;
  // Later ops of a chain accumulate onto the previous (registered) ALU result.
  assign alu_a      = first_q ? head.a : alu_out;
  assign alu_b      = head.b;

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_error = res_error_q;
  assign res_ops   = res_ops_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W = 16;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int TIMEOUT = 200;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MULT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR = 3'd5;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_last;
  logic [2:0] in_opcode, alu_opcode;
  logic [W-1:0] in_a, in_b, alu_a, alu_b, alu_out, res_data;
  logic alu_rst, alu_status, res_valid, res_ready, res_error, busy;
  logic [CW-1:0] res_ops;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int issue_cnt = 0;
  int last_issue = 0;

  // Current chain under test.
  logic [2:0] ch_op[$];
  logic [W-1:0] ch_b[$];
  logic [W-1:0] ch_a;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .DEPTH(DEPTH),
    .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_opcode(in_opcode),
    .in_a(in_a),
    .in_b(in_b),
    .in_last(in_last),
    .alu_rst(alu_rst),
    .alu_opcode(alu_opcode),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_out(alu_out),
    .alu_status(alu_status),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_error(res_error),
    .res_ops(res_ops),
    .busy(busy)
  );

  // ALU operation: returns {error, result}.
  function automatic logic [W:0] alu_calc(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] wide;
    logic [W-1:0] r;
    logic err;
    wide = '0;
    r = '0;
    err = 1'b0;
    case (op)
      3'd0: begin wide = (2*W)'(a) + (2*W)'(b); r = wide[W-1:0]; err = |wide[2*W-1:W]; end
      3'd1: begin r = a - b; err = (a < b); end
      3'd2: begin wide = (2*W)'(a) * (2*W)'(b); r = wide[W-1:0]; err = |wide[2*W-1:W]; end
      3'd3: begin wide = (2*W)'(a) << b[3:0]; r = wide[W-1:0]; err = |wide[2*W-1:W]; end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = ~a;
    endcase
    return {err, r};
  endfunction

  // ALU with synchronous reset; also tracks issue cycles (alu_rst low) for the checks.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_rst) begin
      alu_out <= '0;
      alu_status <= 1'b0;
    end else begin
      {alu_status, alu_out} <= alu_calc(alu_opcode, alu_a, alu_b);
      issue_cnt <= issue_cnt + 1;
      last_issue <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_opcode = op;
    in_a = a;
    in_b = b;
    in_last = last;
    while (in_ready !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("res_valid_seen", 32'(res_valid), 32'd1);
    lat = cyc - last_issue;
  endtask

  task automatic ack(input int delay);
    for (int d = 0; d < delay; d++) begin
      @(posedge clk);
      #1;
    end
    check("res_valid_hold", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("res_valid_clear", 32'(res_valid), 32'd0);
  endtask

  // Reference: accumulate the chain op by op, stopping at the first op that errors.
  task automatic model(output logic [W-1:0] d, output logic e, output int ops);
    logic [W:0] r;
    logic [W-1:0] acc;
    acc = ch_a;
    e = 1'b0;
    ops = 0;
    for (int i = 0; i < ch_op.size(); i++) begin
      r = alu_calc(ch_op[i], acc, ch_b[i]);
      acc = r[W-1:0];
      ops = i + 1;
      if (r[W]) begin
        e = 1'b1;
        break;
      end
    end
    d = acc;
  endtask

  task automatic run_chain(input string tag, input int ack_delay);
    int i0, lat, exp_ops;
    logic [W-1:0] exp_d;
    logic exp_e;
    i0 = issue_cnt;
    for (int i = 0; i < ch_op.size(); i++) begin
      // A operand of non-first entries is junk; it must be ignored.
      push(ch_op[i], (i == 0) ? ch_a : ~ch_a, ch_b[i], (i == ch_op.size() - 1));
    end
    model(exp_d, exp_e, exp_ops);
    wait_valid(lat);
    check({tag, "_data"}, 32'(res_data), 32'(exp_d));
    check({tag, "_error"}, 32'(res_error), 32'(exp_e));
    check({tag, "_ops"}, 32'(res_ops), 32'(exp_ops));
    check({tag, "_issued"}, 32'(issue_cnt - i0), 32'(exp_ops));
    if (!exp_e) check({tag, "_latency"}, 32'(lat), 32'd2);
    ack(ack_delay);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i0, lat, len;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_opcode = '0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b0;

    // 1. Reset state, then release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_rst", 32'(alu_rst), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_error", 32'(res_error), 32'd0);
    check("rst_res_ops", 32'(res_ops), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rel_alu_rst", 32'(alu_rst), 32'd1);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_res_valid", 32'(res_valid), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);

    // 2. Single ADD.
    ch_a = 16'd5; ch_op = '{OP_ADD}; ch_b = '{16'd7};
    run_chain("t2", 0);
    check("t2_value", 32'(res_data), 32'd12);

    // 3. ADD, MULT, SUB.
    ch_a = 16'd3; ch_op = '{OP_ADD, OP_MULT, OP_SUB}; ch_b = '{16'd4, 16'd5, 16'd1};
    run_chain("t3", 1);
    check("t3_value", 32'(res_data), 32'd34);

    // 4. Carry on the first op aborts the chain; the next chain is unaffected.
    ch_a = 16'hFFF0; ch_op = '{OP_ADD, OP_AND, OP_OR}; ch_b = '{16'h0020, 16'h00FF, 16'h0001};
    run_chain("t4", 0);
    check("t4_value", 32'(res_data), 32'h0010);
    check("t4_err", 32'(res_error), 32'd1);
    ch_a = 16'd1; ch_op = '{OP_ADD}; ch_b = '{16'd1};
    run_chain("t4b", 0);
    check("t4b_value", 32'(res_data), 32'd2);

    // 5. Forced last after DEPTH entries; second chain waits for the result handshake.
    i0 = issue_cnt;
    push(OP_ADD, 16'd1, 16'd2, 1'b0);
    push(OP_ADD, 16'hAAAA, 16'd3, 1'b0);
    push(OP_ADD, 16'hAAAA, 16'd4, 1'b0);
    push(OP_ADD, 16'hAAAA, 16'd5, 1'b0);
    check("t5_full", 32'(in_ready), 32'd0);
    push(OP_ADD, 16'd10, 16'd20, 1'b0);
    push(OP_SUB, 16'hAAAA, 16'd5, 1'b1);
    wait_valid(lat);
    check("t5a_data", 32'(res_data), 32'd15);
    check("t5a_ops", 32'(res_ops), 32'd4);
    check("t5a_issued", 32'(issue_cnt - i0), 32'd4);
    repeat (8) @(posedge clk);
    #1;
    check("t5_hold_valid", 32'(res_valid), 32'd1);
    check("t5_hold_busy", 32'(busy), 32'd0);
    check("t5_hold_issued", 32'(issue_cnt - i0), 32'd4);
    ack(0);
    i0 = issue_cnt;
    wait_valid(lat);
    check("t5b_data", 32'(res_data), 32'd25);
    check("t5b_error", 32'(res_error), 32'd0);
    check("t5b_ops", 32'(res_ops), 32'd2);
    check("t5b_issued", 32'(issue_cnt - i0), 32'd2);
    check("t5b_latency", 32'(lat), 32'd2);
    ack(0);

    // 6. Reset in the second cycle of a 4-op run.
    i0 = issue_cnt;
    push(OP_ADD, 16'd2, 16'd3, 1'b0);
    push(OP_ADD, 16'd0, 16'd4, 1'b0);
    push(OP_ADD, 16'd0, 16'd5, 1'b0);
    push(OP_ADD, 16'd0, 16'd6, 1'b1);
    len = 0;
    while (busy !== 1'b1 && len < TIMEOUT) begin
      @(posedge clk);
      #1;
      len++;
    end
    check("t6_started", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_alu_rst", 32'(alu_rst), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t6_no_result", 32'(res_valid), 32'd0);
    check("t6_stay_idle", 32'(busy), 32'd0);
    check("t6_issued", 32'(issue_cnt - i0), 32'd1);
    ch_a = 16'd9; ch_op = '{OP_SUB, OP_ADD}; ch_b = '{16'd4, 16'd100};
    run_chain("t6b", 0);

    // Random chains against the reference model.
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, DEPTH);
      ch_op = {};
      ch_b = {};
      ch_a = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 255));
      for (int i = 0; i < len; i++) begin
        ch_op.push_back(3'($urandom_range(0, 7)));
        ch_b.push_back(($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 15)));
      end
      run_chain("rnd", $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
